// File: rtl/aes_in_packer.sv
// aes_in_packer: assembles four 32-bit host words into a 128-bit AES
// controller input packet, buffers packets in a 2-entry FIFO and enforces
// a key-schedule hold-off after every key packet leaves the block.
//
// Optional build macro: AES_PACKER_BSWAP_EN
//   defined   - each host word is byte-reversed before placement
//   undefined - host words are placed unmodified
//
// pkt_out layout (matches a packed in_packet_t, MSB first):
//   [130] valid, [129:2] data, [1] en_de, [0] set_key
module aes_in_packer #(
    parameter int unsigned KEY_GAP    = 11,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         host_valid,
    output logic         host_ready,
    input  logic [31:0]  host_data,
    input  logic         host_en_de,
    input  logic         host_set_key,
    output logic [130:0] pkt_out,
    input  logic         pkt_ready,
    output logic         busy
);

    localparam int unsigned GW = (KEY_GAP < 2) ? 1 : $clog2(KEY_GAP + 1);

    logic [1:0]    idx;
    logic          en_de_l;
    logic          set_key_l;
    logic [95:0]   asm_reg;
    logic [129:0]  mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic [GW-1:0] gap_cnt;

    logic [31:0]   word;
    logic          handshake;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          out_valid;
    logic [129:0]  head;

`ifdef AES_PACKER_BSWAP_EN
    assign word = {host_data[7:0], host_data[15:8], host_data[23:16], host_data[31:24]};
`else
    assign word = host_data;
`endif

    assign fifo_full  = (count == 2'(FIFO_DEPTH));
    assign fifo_empty = (count == 2'd0);
    assign head       = mem[rd_ptr];

    // Handshake, push/pop qualifiers and the externally visible outputs
    always_comb begin
        host_ready = !((idx == 2'd3) && fifo_full);
        handshake  = host_valid && host_ready;
        push       = handshake && (idx == 2'd3) && !flush;
        out_valid  = !fifo_empty && (gap_cnt == '0);
        pop        = out_valid && pkt_ready;
        pkt_out    = '0;
        if (!fifo_empty) begin
            pkt_out = {out_valid, head};
        end
        busy = (idx != 2'd0) || !fifo_empty || (gap_cnt != '0);
    end

    // Packet storage; contents are only observed through count-gated reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {asm_reg, word, en_de_l, set_key_l};
        end
    end

    // Word assembly, FIFO pointers/count and key-gap counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            en_de_l   <= 1'b0;
            set_key_l <= 1'b0;
            asm_reg   <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= '0;
            gap_cnt   <= '0;
        end else if (flush) begin
            idx       <= '0;
            en_de_l   <= 1'b0;
            set_key_l <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= '0;
            gap_cnt   <= '0;
        end else begin
            if (handshake) begin
                idx <= idx + 2'd1;
                if (idx == 2'd0) begin
                    en_de_l   <= host_en_de;
                    set_key_l <= host_set_key;
                end
                case (idx)
                    2'd0:    asm_reg[95:64] <= word;
                    2'd1:    asm_reg[63:32] <= word;
                    2'd2:    asm_reg[31:0]  <= word;
                    default: ;
                endcase
            end
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
            // pop only happens with gap_cnt==0, so the load never collides with a decrement
            if (pop && head[0]) begin
                gap_cnt <= GW'(KEY_GAP);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end

endmodule

// File: tb/tb_aes_in_packer.sv
// Scoreboard bench for aes_in_packer: expected packets are queued when a
// packet is issued; a negedge monitor pops and compares on every accepted
// pkt_out. Directed checks cover reset, timing, backpressure and flush.
module tb_aes_in_packer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         host_valid = 1'b0;
    logic         host_ready;
    logic [31:0]  host_data = '0;
    logic         host_en_de = 1'b0;
    logic         host_set_key = 1'b0;
    logic [130:0] pkt_out;
    logic         pkt_ready = 1'b0;
    logic         busy;

    int           n_cmp = 0;
    int           n_bad = 0;
    int unsigned  cyc = 0;
    logic [129:0] exp_q[$];
    int unsigned  pop_cyc[$];
    logic [129:0] mon_exp;
    int unsigned  base;

    aes_in_packer #(.KEY_GAP(11), .FIFO_DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_data    (host_data),
        .host_en_de   (host_en_de),
        .host_set_key (host_set_key),
        .pkt_out      (pkt_out),
        .pkt_ready    (pkt_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef AES_PACKER_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [129:0] mk(input logic [127:0] d, input logic e, input logic k);
        return {sw(d[127:96]), sw(d[95:64]), sw(d[63:32]), sw(d[31:0]), e, k};
    endfunction

    task automatic check(input string name, input logic [130:0] act, input logic [130:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Monitor: every accepted packet is compared against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && pkt_out[130] && pkt_ready) begin
            pop_cyc.push_back(cyc + 1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pkt: got %h expected none", pkt_out[129:0]);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pkt", {1'b1, pkt_out[129:0]}, {1'b1, mon_exp});
            end
        end
    end

    task automatic send_word(input logic [31:0] w, input logic e, input logic k);
        bit ok;
        int n;
        n = 0;
        host_valid = 1'b1;
        host_data = w;
        host_en_de = e;
        host_set_key = k;
        do begin
            @(negedge clk);
            ok = host_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 300);
        if (!ok) fail_timeout("handshake");
    endtask

    // Flags are inverted on words 1..3 to confirm only word 0 is sampled
    task automatic send_pkt(input logic [127:0] d, input logic e, input logic k);
        exp_q.push_back(mk(d, e, k));
        send_word(d[127:96], e, k);
        send_word(d[95:64], !e, !k);
        send_word(d[63:32], !e, !k);
        send_word(d[31:0], !e, !k);
        host_valid = 1'b0;
    endtask

    task automatic wait_pops(input int unsigned n);
        for (int i = 0; i < 400 && pop_cyc.size() < n; i++) @(negedge clk);
        if (pop_cyc.size() < n) fail_timeout("wait_pops");
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) fail_timeout("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with host_valid asserted
        host_valid = 1'b1;
        host_data = 32'hFFFF_FFFF;
        #12;
        check("rst_host_ready", {130'd0, host_ready}, {130'd0, 1'b1});
        check("rst_busy", {130'd0, busy}, 131'd0);
        check("rst_pkt_out", pkt_out, 131'd0);
        host_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Data packet: nothing until the 4th word, then valid for one cycle
        pkt_ready = 1'b1;
        exp_q.push_back(mk(128'hDEADBEEF_CAFE1234_5678ABCD_01234567, 1'b1, 1'b0));
        send_word(32'hDEADBEEF, 1'b1, 1'b0);
        send_word(32'hCAFE1234, 1'b0, 1'b1);
        send_word(32'h5678ABCD, 1'b0, 1'b1);
        host_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_pkt_partial", {130'd0, pkt_out[130]}, 131'd0);
        end
        @(posedge clk);
        #1;
        send_word(32'h01234567, 1'b0, 1'b1);
        host_valid = 1'b0;
        @(negedge clk);
        check("valid_after_4th", {130'd0, pkt_out[130]}, {130'd0, 1'b1});
        @(negedge clk);
        check("valid_one_cycle", {130'd0, pkt_out[130]}, 131'd0);
        wait_drain();

        // Key gap: data packet pops 12 cycles after the key pop
        base = pop_cyc.size();
        send_pkt(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b1);
        send_pkt(128'h11111111_22222222_33333333_44444444, 1'b1, 1'b0);
        wait_pops(base + 2);
        if (pop_cyc.size() >= base + 2)
            check("key_gap_spacing", 131'(pop_cyc[base + 1] - pop_cyc[base]), 131'd12);
        wait_drain();

        // Backpressure: FIFO fills, host_ready low at idx==3
        pkt_ready = 1'b0;
        send_pkt(128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3, 1'b1, 1'b0);
        send_pkt(128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3, 1'b0, 1'b0);
        exp_q.push_back(mk(128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3, 1'b1, 1'b0));
        send_word(32'hC0C0C0C0, 1'b1, 1'b0);
        send_word(32'hC1C1C1C1, 1'b0, 1'b1);
        send_word(32'hC2C2C2C2, 1'b0, 1'b1);
        host_valid = 1'b0;
        @(negedge clk);
        check("bp_host_ready_low", {130'd0, host_ready}, 131'd0);
        check("bp_busy", {130'd0, busy}, {130'd0, 1'b1});
        pkt_ready = 1'b1;
        #1;
        check("bp_ready_no_same_cycle", {130'd0, host_ready}, 131'd0);
        @(negedge clk);
        check("bp_ready_after_pop", {130'd0, host_ready}, {130'd0, 1'b1});
        @(posedge clk);
        #1;
        send_word(32'hC3C3C3C3, 1'b0, 1'b1);
        host_valid = 1'b0;
        wait_drain();

        // Flush mid-packet
        send_word(32'h99999999, 1'b1, 1'b1);
        send_word(32'h88888888, 1'b1, 1'b1);
        host_valid = 1'b1;
        host_data = 32'h77777777;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        host_valid = 1'b0;
        @(negedge clk);
        check("flush_busy", {130'd0, busy}, 131'd0);
        @(posedge clk);
        #1;
        send_pkt(128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F, 1'b0, 1'b0);
        wait_drain();

        // Async reset five cycles into a key gap
        base = pop_cyc.size();
        send_pkt(128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b1, 1'b1);
        wait_pops(base + 1);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {130'd0, busy}, 131'd0);
        check("arst_host_ready", {130'd0, host_ready}, {130'd0, 1'b1});
        check("arst_pkt_out", pkt_out, 131'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(128'h5A5A5A5A_A5A5A5A5_3C3C3C3C_C3C3C3C3, 1'b1, 1'b0);
        @(negedge clk);
        check("arst_no_gap", {130'd0, pkt_out[130]}, {130'd0, 1'b1});
        wait_drain();

        check("scoreboard_empty", 131'(exp_q.size()), 131'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_in_packer.md
# aes_in_packer

Host-side transmitter for the AES controller's `in_packet_t` input. It accepts 32-bit command/data words over a valid/ready handshake and assembles four words into one 128-bit packet. The packet is buffered in a 2-entry FIFO and presented to the controller as a single-cycle-accepted `in_packet_t`. After a key packet, the block enforces a key-schedule hold-off so the controller's 11-step one-hot round-key load completes before any further packet is presented.

## Interface
Parameters:
- `KEY_GAP`, default 11: idle cycles inserted after a `set_key` packet is accepted downstream.
- `FIFO_DEPTH`, default 2: assembled-packet buffer entries. Only the value 2 is supported.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `flush`  in  1: synchronous clear of the partial word, the FIFO and the gap counter.
- `host_valid`  in  1: host word valid.
- `host_ready`  out  1: block can accept a word.
- `host_data`  in  32: word; the first word of a packet is bits [127:96].
- `host_en_de`  in  1: encrypt/decrypt select; sampled on word 0 only.
- `host_set_key`  in  1: marks the packet as a key; sampled on word 0 only.
- `pkt_out`  out  `in_packet_t`: fields `valid`, `data[127:0]`, `en_de`, `set_key`.
- `pkt_ready`  in  1: controller accepts `pkt_out` this cycle.
- `busy`  out  1: high when a partial packet is held, the FIFO is non-empty, or the gap counter is non-zero.

## Operation
- **Word counter** `idx` (2 bits, 0..3):
  - Increments on each handshake (`host_valid && host_ready`) and wraps from 3 to 0.
  - Word k is placed in bits [127-32k -: 32].
  - `en_de` and `set_key` are latched when `idx==0`. Their values on words 1..3 are ignored.
- **Push:** on the handshake where `idx==3`, the concatenation {words 0..2, current word} plus the latched flags is written into the FIFO at that same edge.
- **host_ready:** `!(idx==3 && fifo_full)`. A pop in the same cycle does not raise it; this is deliberately conservative and combinational only from FIFO state.
- **pkt_out.valid:** `fifo_count != 0 && gap_cnt == 0`.
  - `pkt_out.data`, `pkt_out.en_de` and `pkt_out.set_key` show the FIFO head and are held stable while valid is high and `pkt_ready` is low.
  - All fields are 0 when the FIFO is empty.
- **Pop:** `pkt_out.valid && pkt_ready`.
  - Push and pop in the same cycle keeps the count unchanged.
- **Gap counter** (4 bits for the default `KEY_GAP`):
  - Loaded with `KEY_GAP` on a pop whose head has `set_key=1`.
  - Decrements by 1 each cycle while non-zero.
  - While non-zero, `pkt_out.valid` is forced low for all packets. Word assembly and pushes continue.
- **flush:** takes priority over any handshake in the same cycle. It clears `idx`, the latched flags, the FIFO and `gap_cnt` at the next edge. The word offered in the flush cycle is dropped.
- **Reset:** `rst_n` low asynchronously clears `idx`, the flags, the assembly register, the FIFO pointers/count and `gap_cnt`. A partial packet is discarded and is never emitted.
- **Reset values of outputs:**
  - `host_ready=1`
  - `pkt_out='0`
  - `busy=0`

## Timing
- A 4th-word handshake at edge N makes `pkt_out.valid` high in the cycle after N, provided `gap_cnt==0`.
- Best-case throughput is one packet per 4 cycles, sustained with `pkt_ready` tied high.
- Key pop at edge M:
  - `pkt_out.valid` is low for the cycles after edges M .. M+KEY_GAP-1.
  - The next packet can be accepted at edge M+KEY_GAP+1 at the earliest.
- With the FIFO full and `idx==3`, `host_ready` is low. It rises the cycle after the pop edge.
- Back-to-back key packets are each followed by their own gap.

## Configuration
- `AES_PACKER_BSWAP_EN`:
  - Defined: every `host_data` word is byte-reversed before placement, so byte 0 of the word lands in bits [31:24] of its slot. This supports little-endian hosts.
  - Undefined: words are placed unmodified.
  - Handshake behaviour, timing and gap behaviour are identical in both builds.

## Test plan
- **Reset:** hold `rst_n=0` with `host_valid=1` → `host_ready=1`, `pkt_out='0`, `busy=0`. No packet appears after release until 4 words are sent.
- **Data packet:** words DEADBEEF, CAFE1234, 5678ABCD, 01234567 with `en_de=1`, `set_key=0`, and `pkt_ready=1` → `pkt_out.data=128'hDEADBEEF_CAFE1234_5678ABCD_01234567`, `en_de=1`, valid for exactly 1 cycle, 1 cycle after the 4th handshake. With the macro defined, data is EFBEADDE_3412FECA_CDAB7856_67452301.
- **Key gap:** key packet 000102030405060708090a0b0c0d0e0f (`set_key=1`) immediately followed by a data packet → the key is popped; `pkt_out.valid` stays low for 11 cycles; the data packet pops 12 cycles after the key pop.
- **Backpressure:** `pkt_ready=0` while sending 3 packets → the FIFO fills after 2 packets and `host_ready` goes low with `idx==3`. Raising `pkt_ready` drains the packets in order, and `host_ready` rises 1 cycle after the first pop.
- **Flush mid-packet:** send 2 words, assert `flush`, then send 4 new words → only the new 4-word packet is emitted, and `busy` drops to 0 after the flush edge.
- **Async reset mid-gap:** assert `rst_n=0` between edges 5 cycles into a key gap → `gap_cnt`, the FIFO and `idx` are cleared immediately. After release, a new data packet is emitted with no residual gap.
